pipeline_divider_param: RTL and testbench
=========================================

# pipeline_divider_param

Parametrised, fully pipelined restoring divider with valid/ready flow control. It generalises the fixed 28/20-bit, 8-stage divider used in the datapath and adds a remainder output, a pass-through tag, a divide-by-zero flag, an overflow flag and stall-on-backpressure. It sits between the accumulator stage and the normalisation/output stage, accepts one division per cycle, and returns results in issue order.

## Interface
- DIVIDEND_W, default 28: dividend width.
- DIVISOR_W, default 20: divisor width. The block requires DIVIDEND_W > DIVISOR_W.
- Q_W, derived, = DIVIDEND_W - DIVISOR_W (8 by default): quotient width. This is also the number of pipeline stages.
- TAG_W, default 4: width of the sideband tag.

Ports:
- clock, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all valid bits and data registers.
- in_valid, input, 1: an operand pair is presented.
- in_ready, output, 1: the block accepts an operand pair this cycle.
- dividend, input, DIVIDEND_W: unsigned dividend.
- divisor, input, DIVISOR_W: unsigned divisor.
- in_tag, input, TAG_W: opaque sideband, returned unchanged with the result.
- out_valid, output, 1: a result is presented.
- out_ready, input, 1: the consumer accepts the result.
- quotient, output, Q_W: unsigned quotient.
- remainder, output, DIVISOR_W: unsigned remainder.
- out_tag, output, TAG_W: tag of the result.
- div_by_zero, output, 1: divisor was 0.
- overflow, output, 1: the quotient does not fit in Q_W bits.

## Operation
- **Pipeline.** Q_W stages, each with one register bank: valid, partial remainder (DIVISOR_W+1 bits), remaining dividend bits, divisor, partial quotient, tag and the two flags.
- **Entry check.** Let hi = dividend[DIVIDEND_W-1:Q_W].
  - overflow is set when hi >= divisor.
  - div_by_zero is set when divisor == 0, and overflow is also set in that case.
- **Stage k (k = 0..Q_W-1).**
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - Compute trial = partial - {1'b0, divisor}, using DIVISOR_W+1-bit arithmetic.
  - If trial is non-negative, write trial back and set quotient bit Q_W-1-k. Otherwise keep partial and clear that bit.
- **Stage 0 seeding.** Stage 0 loads partial = {1'b0, hi}.
- **Output for a normal result.** quotient = final quotient bits; remainder = final partial[DIVISOR_W-1:0]. The result satisfies dividend = quotient*divisor + remainder, with remainder < divisor.
- **Output for an overflow result (including divide-by-zero).** quotient = all ones and remainder = 0, regardless of the arithmetic path. Flags travel with the data.
- **Flow control.**
  - advance = !out_valid || out_ready.
  - When advance is high, every stage loads from its predecessor, and stage 0 loads {in_valid, operands}.
  - When advance is low, every stage holds.
  - in_ready = advance.
  - Bubbles travel through the pipeline. They are not collapsed.
- **Transfer rules.**
  - A transfer in happens when in_valid && in_ready.
  - A transfer out happens when out_valid && out_ready.
  - Both may happen in the same cycle.
  - out_* data is stable while out_valid && !out_ready.
- **Reset.**
  - Outputs after reset: out_valid=0, quotient=0, remainder=0, out_tag=0, div_by_zero=0, overflow=0, in_ready=1.
  - A reset asserted mid-operation discards every in-flight operation. No partial results are emitted after reset is released.

## Timing
- Latency is Q_W cycles, 8 by default. An operand accepted at edge N produces out_valid at edge N+Q_W, provided advance stayed high.
- Each cycle with advance low adds exactly one cycle of latency to every in-flight operation.
- Throughput is one operation per cycle while out_ready=1.
- in_ready depends combinationally on out_ready, with no registered slack. Upstream must not make in_valid depend on in_ready.
- The critical path is one DIVISOR_W+1-bit subtractor plus a mux per stage.

## Structure
- **Package divider_pkg** holds:
  - default width constants (DIVIDEND_W_DEF = 28, DIVISOR_W_DEF = 20, TAG_W_DEF = 4);
  - the stage payload struct, parametrised by width via localparams in the top;
  - a qw() helper function.
- **Sub-module divider_stage** is one parametrised stage: shift, trial subtract, quotient-bit set, and enable-gated register. The top instantiates it Q_W times with a generate loop and adds the entry check and the overflow output mux.

## Test plan
- **Basic division.** dividend=1000, divisor=7, tag=3 → after 8 cycles: quotient=142, remainder=6, out_tag=3, both flags 0.
- **Maximum in-range case.** dividend=0x7FFFFFF, divisor=0x80000 → quotient=255, remainder=0x7FFFF, overflow=0. Then dividend=768, divisor=3 → overflow=1, quotient=0xFF, remainder=0.
- **Divide by zero.** divisor=0, dividend=12345 → div_by_zero=1, overflow=1, quotient=0xFF, remainder=0.
- **Streaming with backpressure.**
  - Stimulus: 20 back-to-back random in-range operations, with out_ready held low for 3 cycles mid-stream.
  - Required: in_ready is low for exactly those 3 cycles, all 20 results are correct, in order, and carry matching tags, and out_* is stable during the stall.
- **Reset mid-operation.** Issue 5 operations, assert reset for 1 cycle after 4 edges → out_valid stays 0 until fresh input arrives, and the next operation (100/9) returns quotient=11, remainder=1 after 8 cycles.
- **Parameter sweep.** Instantiate with DIVIDEND_W=16, DIVISOR_W=8 → latency is 8, and exhaustive checks on 2000 random in-range pairs match the reference model.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared constants, types and helpers for the parametrised pipelined divider.
package divider_pkg;

   localparam int DIVIDEND_W_DEF = 28;
   localparam int DIVISOR_W_DEF  = 20;
   localparam int TAG_W_DEF      = 4;

   // Status flags that travel alongside every operation through the pipe.
   typedef struct packed {
      logic dbz;   // divisor was zero
      logic ovf;   // quotient does not fit in Q_W bits
   } div_flags_t;

   // Quotient width, which is also the number of restoring stages.
   function automatic int qw(input int dividend_w, input int divisor_w);
      return dividend_w - divisor_w;
   endfunction

endpackage

// File: rtl/divider_stage.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract the divisor, produce one quotient bit, and register everything
// behind a common advance enable so the whole pipe stalls in lock-step.
module divider_stage
   import divider_pkg::*;
#(
   parameter int DIVISOR_W = DIVISOR_W_DEF,
   parameter int Q_W       = 8,
   parameter int TAG_W     = TAG_W_DEF
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en_i,
   input  logic                 vld_i,
   input  logic [DIVISOR_W:0]   part_i,
   input  logic [Q_W-1:0]       dbits_i,
   input  logic [DIVISOR_W-1:0] dsr_i,
   input  logic [Q_W-1:0]       quo_i,
   input  logic [TAG_W-1:0]     tag_i,
   input  div_flags_t           flags_i,
   output logic                 vld_o,
   output logic [DIVISOR_W:0]   part_o,
   output logic [Q_W-1:0]       dbits_o,
   output logic [DIVISOR_W-1:0] dsr_o,
   output logic [Q_W-1:0]       quo_o,
   output logic [TAG_W-1:0]     tag_o,
   output div_flags_t           flags_o
);

   logic [DIVISOR_W+1:0] shifted;
   logic                 ge;
   logic [DIVISOR_W:0]   part_d;
   logic [Q_W-1:0]       dbits_d;
   logic [Q_W-1:0]       quo_d;

   logic                 vld_q;
   logic [DIVISOR_W:0]   part_q;
   logic [Q_W-1:0]       dbits_q;
   logic [DIVISOR_W-1:0] dsr_q;
   logic [Q_W-1:0]       quo_q;
   logic [TAG_W-1:0]     tag_q;
   div_flags_t           flags_q;

   // Shift/trial-subtract step; the compare uses the full shifted value so an
   // out-of-range operand cannot wrap, while the subtract itself is
   // DIVISOR_W+1 bits wide (the quotient is forced later for such operands).
   always_comb begin
      shifted = {part_i, dbits_i[Q_W-1]};
      ge      = (shifted >= {2'b00, dsr_i});
      part_d  = ge ? (shifted[DIVISOR_W:0] - {1'b0, dsr_i}) : shifted[DIVISOR_W:0];
      dbits_d = dbits_i << 1;
      quo_d   = (quo_i << 1) | Q_W'(ge);
   end

   // Stage register bank, held whenever the pipe is stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q   <= 1'b0;
         part_q  <= '0;
         dbits_q <= '0;
         dsr_q   <= '0;
         quo_q   <= '0;
         tag_q   <= '0;
         flags_q <= '0;
      end else if (en_i) begin
         vld_q   <= vld_i;
         part_q  <= part_d;
         dbits_q <= dbits_d;
         dsr_q   <= dsr_i;
         quo_q   <= quo_d;
         tag_q   <= tag_i;
         flags_q <= flags_i;
      end
   end

   assign vld_o   = vld_q;
   assign part_o  = part_q;
   assign dbits_o = dbits_q;
   assign dsr_o   = dsr_q;
   assign quo_o   = quo_q;
   assign tag_o   = tag_q;
   assign flags_o = flags_q;

endmodule

// File: rtl/pipeline_divider_param.sv
// Fully pipelined unsigned restoring divider with valid/ready flow control.
// Q_W = DIVIDEND_W - DIVISOR_W step stages plus a registered output bank
// give a latency of Q_W cycles; DIVIDEND_W must exceed DIVISOR_W.
module pipeline_divider_param
   import divider_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF,
   parameter int TAG_W      = TAG_W_DEF
)(
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DIVIDEND_W-1:0]           dividend,
   input  logic [DIVISOR_W-1:0]            divisor,
   input  logic [TAG_W-1:0]                in_tag,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DIVIDEND_W-DIVISOR_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]            remainder,
   output logic [TAG_W-1:0]                out_tag,
   output logic                            div_by_zero,
   output logic                            overflow
);

   localparam int Q_W = qw(DIVIDEND_W, DIVISOR_W);

   // Result payload held in the output bank.
   typedef struct packed {
      logic [Q_W-1:0]       quo;
      logic [DIVISOR_W-1:0] rem;
      logic [TAG_W-1:0]     tag;
      div_flags_t           flags;
   } result_t;

   // Index 0 is the stage-0 input; index k+1 is the output of stage k.
   logic [Q_W:0]                  vld;
   logic [Q_W:0][DIVISOR_W:0]     part;
   logic [Q_W:0][Q_W-1:0]         dbits;
   logic [Q_W:0][DIVISOR_W-1:0]   dsr;
   logic [Q_W:0][Q_W-1:0]         quo;
   logic [Q_W:0][TAG_W-1:0]       tag;
   div_flags_t [Q_W:0]            flg;

   logic [DIVISOR_W-1:0] hi;
   logic                 advance;
   logic                 out_valid_q;
   result_t              result_d;
   result_t              result_q;
   logic                 unused_tail;

   // The pipe moves as one unit whenever the output slot is free or drained.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Entry check and stage-0 seeding from the upper dividend bits.
   assign hi       = dividend[DIVIDEND_W-1:Q_W];
   assign vld[0]   = in_valid;
   assign part[0]  = {1'b0, hi};
   assign dbits[0] = dividend[Q_W-1:0];
   assign dsr[0]   = divisor;
   assign quo[0]   = '0;
   assign tag[0]   = in_tag;
   assign flg[0].dbz = (divisor == '0);
   assign flg[0].ovf = (hi >= divisor);

   for (genvar k = 0; k < Q_W; k++) begin : g_stage
      divider_stage #(
         .DIVISOR_W (DIVISOR_W),
         .Q_W       (Q_W),
         .TAG_W     (TAG_W)
      ) u_stage (
         .clock   (clock),
         .reset   (reset),
         .en_i    (advance),
         .vld_i   (vld[k]),
         .part_i  (part[k]),
         .dbits_i (dbits[k]),
         .dsr_i   (dsr[k]),
         .quo_i   (quo[k]),
         .tag_i   (tag[k]),
         .flags_i (flg[k]),
         .vld_o   (vld[k+1]),
         .part_o  (part[k+1]),
         .dbits_o (dbits[k+1]),
         .dsr_o   (dsr[k+1]),
         .quo_o   (quo[k+1]),
         .tag_o   (tag[k+1]),
         .flags_o (flg[k+1])
      );
   end

   // After the last step the dividend bits are exhausted, the divisor is no
   // longer needed and the partial MSB is zero for any in-range operand.
   assign unused_tail = ^{dbits[Q_W], dsr[Q_W], part[Q_W][DIVISOR_W]};

   // Overflow results report all-ones quotient and zero remainder.
   always_comb begin
      result_d.quo   = flg[Q_W].ovf ? '1 : quo[Q_W];
      result_d.rem   = flg[Q_W].ovf ? '0 : part[Q_W][DIVISOR_W-1:0];
      result_d.tag   = tag[Q_W];
      result_d.flags = flg[Q_W];
   end

   // Output bank: holds steady while the consumer back-pressures.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else if (advance) begin
         out_valid_q <= vld[Q_W];
         result_q    <= result_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign quotient    = result_q.quo;
   assign remainder   = result_q.rem;
   assign out_tag     = result_q.tag;
   assign div_by_zero = result_q.flags.dbz;
   assign overflow    = result_q.flags.ovf;

endmodule

// File: tb/tb_pipeline_divider_param.sv
// Directed bench for pipeline_divider_param: default 28/20 instance plus a
// 16/8 instance for the parameter sweep.
module tb_pipeline_divider_param;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;
   int   cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Default instance signals
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [27:0] a_dividend;
   logic [19:0] a_divisor;
   logic [3:0]  a_in_tag, a_out_tag;
   logic [7:0]  a_quotient;
   logic [19:0] a_remainder;
   logic        a_dbz, a_ovf;

   // 16/8 instance signals
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [15:0] b_dividend;
   logic [7:0]  b_divisor;
   logic [3:0]  b_in_tag, b_out_tag;
   logic [7:0]  b_quotient;
   logic [7:0]  b_remainder;
   logic        b_dbz, b_ovf;

   pipeline_divider_param u_dut_a (
      .clock(clock), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .dividend(a_dividend), .divisor(a_divisor), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .quotient(a_quotient), .remainder(a_remainder), .out_tag(a_out_tag),
      .div_by_zero(a_dbz), .overflow(a_ovf)
   );

   pipeline_divider_param #(.DIVIDEND_W(16), .DIVISOR_W(8), .TAG_W(4)) u_dut_b (
      .clock(clock), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .dividend(b_dividend), .divisor(b_divisor), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .quotient(b_quotient), .remainder(b_remainder), .out_tag(b_out_tag),
      .div_by_zero(b_dbz), .overflow(b_ovf)
   );

   int total = 0;
   int bad   = 0;

   // expected results in issue order: quotient, remainder, tag, {dbz,ovf}, accept edge (-1 = no latency check)
   int aq_q[$], aq_r[$], aq_t[$], aq_f[$], aq_c[$];
   int bq_q[$], bq_r[$], bq_t[$], bq_f[$], bq_c[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of the default instance: drive, settle, score, advance.
   task automatic step_a(input logic v, input logic [27:0] dd, input logic [19:0] ds,
                         input logic [3:0] tg, input logic ordy,
                         input int eq, input int er, input int ef, input bit lat,
                         output bit acc, output logic [63:0] snap);
      int c;
      a_in_valid = v; a_dividend = dd; a_divisor = ds; a_in_tag = tg; a_out_ready = ordy;
      #1;
      snap = {28'd0, a_out_valid, a_quotient, a_remainder, a_out_tag, a_dbz, a_ovf, a_in_ready};
      if (a_out_valid && a_out_ready) begin
         if (aq_q.size() == 0) chk("a_spurious_out", a_out_valid, 0);
         else begin
            chk("a_quotient", a_quotient, aq_q.pop_front());
            chk("a_remainder", a_remainder, aq_r.pop_front());
            chk("a_tag", a_out_tag, aq_t.pop_front());
            chk("a_flags", {a_dbz, a_ovf}, aq_f.pop_front());
            c = aq_c.pop_front();
            if (c >= 0) chk("a_latency", cyc - c, 8);
         end
      end
      acc = a_in_valid && a_in_ready;
      if (acc) begin
         aq_q.push_back(eq); aq_r.push_back(er); aq_t.push_back(tg);
         aq_f.push_back(ef); aq_c.push_back(lat ? cyc + 1 : -1);
      end
      @(posedge clock); #1;
   endtask

   task automatic step_b(input logic v, input logic [15:0] dd, input logic [7:0] ds,
                         input logic [3:0] tg, input logic ordy,
                         input int eq, input int er, input int ef, input bit lat,
                         output bit acc);
      int c;
      b_in_valid = v; b_dividend = dd; b_divisor = ds; b_in_tag = tg; b_out_ready = ordy;
      #1;
      if (b_out_valid && b_out_ready) begin
         if (bq_q.size() == 0) chk("b_spurious_out", b_out_valid, 0);
         else begin
            chk("b_quotient", b_quotient, bq_q.pop_front());
            chk("b_remainder", b_remainder, bq_r.pop_front());
            chk("b_tag", b_out_tag, bq_t.pop_front());
            chk("b_flags", {b_dbz, b_ovf}, bq_f.pop_front());
            c = bq_c.pop_front();
            if (c >= 0) chk("b_latency", cyc - c, 8);
         end
      end
      acc = b_in_valid && b_in_ready;
      if (acc) begin
         bq_q.push_back(eq); bq_r.push_back(er); bq_t.push_back(tg);
         bq_f.push_back(ef); bq_c.push_back(lat ? cyc + 1 : -1);
      end
      @(posedge clock); #1;
   endtask

   task automatic drain_a(input int n);
      bit acc; logic [63:0] snap;
      repeat (n) step_a(1'b0, '0, '0, '0, 1'b1, 0, 0, 0, 1'b0, acc, snap);
      chk("a_drain_empty", aq_q.size(), 0);
   endtask

   task automatic drain_b(input int n);
      bit acc;
      repeat (n) step_b(1'b0, '0, '0, '0, 1'b1, 0, 0, 0, 1'b0, acc);
      chk("b_drain_empty", bq_q.size(), 0);
   endtask

   // Reference: plain integer division with the out-of-range rule applied first.
   function automatic void ref_div(input longint dd, input longint ds, input int q_w,
                                   output int q, output int r, output int f);
      longint hi;
      hi = dd >> q_w;
      f  = 0;
      if (ds == 0) f = 3;
      else if (hi >= ds) f = 1;
      if (f != 0) begin
         q = (1 << q_w) - 1;
         r = 0;
      end else begin
         q = int'(dd / ds);
         r = int'(dd % ds);
      end
   endfunction

   initial begin
      bit          acc;
      logic [63:0] snap, snap0;
      logic [27:0] dd;
      logic [19:0] ds;
      logic [15:0] bdd;
      logic [7:0]  bds;
      int          q, r, f, n, s, low;

      reset = 1'b1;
      a_in_valid = 0; a_dividend = 0; a_divisor = 0; a_in_tag = 0; a_out_ready = 0;
      b_in_valid = 0; b_dividend = 0; b_divisor = 0; b_in_tag = 0; b_out_ready = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // reset state
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_quotient", a_quotient, 0);
      chk("rst_remainder", a_remainder, 0);
      chk("rst_out_tag", a_out_tag, 0);
      chk("rst_div_by_zero", a_dbz, 0);
      chk("rst_overflow", a_ovf, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_b_out_valid", b_out_valid, 0);

      // basic division 1000/7 = 142 r 6
      step_a(1'b1, 28'd1000, 20'd7, 4'd3, 1'b1, 142, 6, 0, 1'b1, acc, snap);
      drain_a(12);

      // largest in-range quotient, then an out-of-range operand back-to-back
      step_a(1'b1, 28'h7FFFFFF, 20'h80000, 4'd5, 1'b1, 255, 'h7FFFF, 0, 1'b1, acc, snap);
      step_a(1'b1, 28'd768, 20'd3, 4'd6, 1'b1, 255, 0, 1, 1'b1, acc, snap);
      drain_a(12);

      // divide by zero
      step_a(1'b1, 28'd12345, 20'd0, 4'd9, 1'b1, 255, 0, 3, 1'b1, acc, snap);
      drain_a(12);

      // 20 back-to-back random operations, consumer stalls on steps 12..14
      n = 0; s = 0; low = 0;
      ds = 20'($urandom_range(1, 20'hFFFFF));
      dd = {20'($urandom % ds), 8'($urandom_range(0, 255))};
      while (n < 20 && s < 200) begin
         ref_div(longint'(dd), longint'(ds), 8, q, r, f);
         step_a(1'b1, dd, ds, 4'(n), !(s >= 12 && s <= 14), q, r, f, 1'b0, acc, snap);
         if (!snap[0]) low++;
         if (s == 12) snap0 = snap;
         if (s >= 12 && s <= 14) chk("a_stall_in_ready", snap[0], 0);
         if (s == 12) chk("a_stall_out_valid", snap[35], 1);
         if (s == 13 || s == 14) chk("a_stall_stable", snap, snap0);
         if (acc) begin
            n++;
            ds = 20'($urandom_range(1, 20'hFFFFF));
            dd = {20'($urandom % ds), 8'($urandom_range(0, 255))};
         end
         s++;
      end
      chk("a_stream_issued", n, 20);
      chk("a_stall_ready_low_cycles", low, 3);
      drain_a(20);

      // reset mid-operation: four ops in flight, fifth presented during reset
      step_a(1'b1, 28'd500, 20'd3, 4'd1, 1'b1, 0, 0, 0, 1'b0, acc, snap);
      step_a(1'b1, 28'd600, 20'd4, 4'd2, 1'b1, 0, 0, 0, 1'b0, acc, snap);
      step_a(1'b1, 28'd700, 20'd5, 4'd3, 1'b1, 0, 0, 0, 1'b0, acc, snap);
      step_a(1'b1, 28'd800, 20'd6, 4'd4, 1'b1, 0, 0, 0, 1'b0, acc, snap);
      a_in_valid = 1'b1; a_dividend = 28'd900; a_divisor = 20'd7; a_in_tag = 4'd5;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      a_in_valid = 1'b0;
      aq_q.delete(); aq_r.delete(); aq_t.delete(); aq_f.delete(); aq_c.delete();
      chk("mid_rst_quotient", a_quotient, 0);
      chk("mid_rst_in_ready", a_in_ready, 1);
      for (int i = 0; i < 10; i++) begin
         step_a(1'b0, '0, '0, '0, 1'b1, 0, 0, 0, 1'b0, acc, snap);
         chk("mid_rst_no_out", snap[35], 0);
      end
      step_a(1'b1, 28'd100, 20'd9, 4'd7, 1'b1, 11, 1, 0, 1'b1, acc, snap);
      drain_a(12);

      // 16/8 instance: latency, then 2000 random in-range pairs with random back-pressure
      step_b(1'b1, 16'd200, 8'd13, 4'd2, 1'b1, 15, 5, 0, 1'b1, acc);
      drain_b(12);
      n = 0; s = 0;
      bds = 8'($urandom_range(1, 255));
      bdd = {8'($urandom % bds), 8'($urandom_range(0, 255))};
      while (n < 2000 && s < 5000) begin
         ref_div(longint'(bdd), longint'(bds), 8, q, r, f);
         step_b(1'b1, bdd, bds, 4'(n), ($urandom_range(0, 9) != 0), q, r, f, 1'b0, acc);
         if (acc) begin
            n++;
            bds = 8'($urandom_range(1, 255));
            bdd = {8'($urandom % bds), 8'($urandom_range(0, 255))};
         end
         s++;
      end
      chk("b_sweep_issued", n, 2000);
      drain_b(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
